// File: rtl/pc_stack_if.sv
// Control-unit to PC-stage bundle: per-instruction decode in, fetch address and stack status out.
// Master is the control unit; slave is pc_stack_unit.
interface pc_stack_if #(
  parameter int ADDR_W = 32,
  parameter int SP_W   = 4
);
  logic              write_pc;
  logic [1:0]        branch;
  logic              push;
  logic              pop;
  logic              halt;
  logic              cond_en;
  logic              cond_flag;
  logic              target_sel;
  logic [ADDR_W-1:0] reg_target;
  logic [15:0]       imm_offset;
  logic [ADDR_W-1:0] pc;
  logic [SP_W-1:0]   sp;
  logic              stack_full;
  logic              stack_empty;
  logic              stack_err;
  logic              halted;

  modport master (
    output write_pc, branch, push, pop, halt, cond_en, cond_flag,
           target_sel, reg_target, imm_offset,
    input  pc, sp, stack_full, stack_empty, stack_err, halted
  );

  modport slave (
    input  write_pc, branch, push, pop, halt, cond_en, cond_flag,
           target_sel, reg_target, imm_offset,
    output pc, sp, stack_full, stack_empty, stack_err, halted
  );
endinterface

// File: rtl/pc_stack_unit.sv
// PC register plus return-address stack; one commit per write_pc strobe, result visible next cycle.
// Define PC_STACK_TRAP_EN to redirect stack overflow/underflow to TRAP_VECTOR.
module pc_stack_unit #(
  parameter int                ADDR_W      = 32,
  parameter int                STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR = ADDR_W'(32'h0000_0004)
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_stack_if.slave   bus
);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;
`ifdef PC_STACK_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              err_q, err_d;
  logic              halted_q, halted_d;
  logic              push_en;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic              full, empty, taken;
  logic [ADDR_W-1:0] pc_inc, rel_tgt, top_entry;

  assign full      = (sp_q == SP_W'(STACK_DEPTH));
  assign empty     = (sp_q == '0);
  assign pc_inc    = pc_q + ADDR_W'(1);
  assign rel_tgt   = pc_inc + ADDR_W'($signed(bus.imm_offset));
  assign top_entry = stack_q[IDX_W'(sp_q - SP_W'(1))];
  assign taken     = ~bus.cond_en | bus.cond_flag;

  always_comb begin
    pc_d     = pc_q;
    sp_d     = sp_q;
    err_d    = err_q;
    halted_d = halted_q;
    push_en  = 1'b0;
    if (bus.write_pc && !halted_q) begin
      if (bus.halt) begin
        halted_d = 1'b1;
      end else begin
        unique case (bus.branch)
          2'b01: begin
            if (bus.push && !bus.pop) begin
              if (!full) begin
                push_en = 1'b1;
                sp_d    = sp_q + SP_W'(1);
                pc_d    = bus.reg_target;
              end else begin
                err_d = 1'b1;
                pc_d  = TrapEn ? TRAP_VECTOR : bus.reg_target;
              end
            end else if (bus.pop && !bus.push) begin
              if (!empty) begin
                sp_d = sp_q - SP_W'(1);
                pc_d = top_entry;
              end else begin
                err_d = 1'b1;
                pc_d  = TrapEn ? TRAP_VECTOR : pc_inc;
              end
            end else begin
              pc_d = pc_inc;
            end
          end
          2'b10:   pc_d = !taken ? pc_inc : (bus.target_sel ? rel_tgt : bus.reg_target);
          default: pc_d = pc_inc;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      sp_q     <= '0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      err_q    <= err_d;
      halted_q <= halted_d;
      if (push_en) stack_q[IDX_W'(sp_q)] <= pc_inc;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.sp          = sp_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_err   = err_q;
  assign bus.halted      = halted_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit; expectations follow the trap build when PC_STACK_TRAP_EN is defined.
module tb_pc_stack_unit;
  localparam int ADDR_W = 32;
  localparam int SP_W   = 4;
`ifdef PC_STACK_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;
  logic [31:0] ret_exp [8];
  logic [31:0] cur_pc;

  always #5 clk = ~clk;

  pc_stack_if #(.ADDR_W(ADDR_W), .SP_W(SP_W)) bus ();
  pc_stack_unit #(.ADDR_W(ADDR_W), .STACK_DEPTH(8), .RESET_PC(32'h0),
                  .TRAP_VECTOR(32'h4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.write_pc = 1'b0; bus.branch = 2'b00; bus.push = 1'b0; bus.pop = 1'b0;
    bus.halt = 1'b0; bus.cond_en = 1'b0; bus.cond_flag = 1'b0; bus.target_sel = 1'b0;
    bus.reg_target = '0; bus.imm_offset = '0;
  endtask

  task automatic commit(input logic [1:0] br, input logic psh, input logic pp, input logic hlt,
                        input logic ce, input logic cf, input logic ts,
                        input logic [31:0] rt, input logic [15:0] imm);
    bus.branch = br; bus.push = psh; bus.pop = pp; bus.halt = hlt; bus.cond_en = ce;
    bus.cond_flag = cf; bus.target_sel = ts; bus.reg_target = rt; bus.imm_offset = imm;
    bus.write_pc = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic seq();                         commit(2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 16'h0); endtask
  task automatic jmp(input logic [31:0] t);     commit(2'b10, 0, 0, 0, 0, 0, 0, t, 16'h0);     endtask
  task automatic call(input logic [31:0] t);    commit(2'b01, 1, 0, 0, 0, 0, 0, t, 16'h0);     endtask
  task automatic ret();                         commit(2'b01, 0, 1, 0, 0, 0, 0, 32'h0, 16'h0); endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    do_reset();
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_sp", 32'(bus.sp), 32'h0);
    chk("rst_empty", 32'(bus.stack_empty), 32'h1);
    chk("rst_full", 32'(bus.stack_full), 32'h0);
    chk("rst_err", 32'(bus.stack_err), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);

    for (int i = 1; i <= 3; i++) begin
      seq();
      chk($sformatf("seq_pc%0d", i), bus.pc, 32'(i));
    end
    chk("seq_sp", 32'(bus.sp), 32'h0);
    chk("seq_empty", 32'(bus.stack_empty), 32'h1);
    chk("seq_err", 32'(bus.stack_err), 32'h0);

    // Decode without the strobe must not change any state.
    bus.branch = 2'b01; bus.push = 1'b1; bus.reg_target = 32'h77;
    @(posedge clk); #1;
    idle_inputs();
    chk("nostrobe_pc", bus.pc, 32'h3);
    chk("nostrobe_sp", 32'(bus.sp), 32'h0);

    jmp(32'h10);
    chk("jmp_pc", bus.pc, 32'h10);
    call(32'h40);
    chk("call_pc", bus.pc, 32'h40);
    chk("call_sp", 32'(bus.sp), 32'h1);
    ret();
    chk("ret_pc", bus.pc, 32'h11);
    chk("ret_sp", 32'(bus.sp), 32'h0);

    jmp(32'h100);
    cur_pc = 32'h100;
    for (int k = 0; k < 8; k++) begin
      ret_exp[k] = cur_pc + 32'h1;
      cur_pc = 32'h200 + 32'(k) * 32'h10;
      call(cur_pc);
    end
    chk("fill_pc", bus.pc, 32'h270);
    chk("fill_sp", 32'(bus.sp), 32'h8);
    chk("fill_full", 32'(bus.stack_full), 32'h1);
    chk("fill_err", 32'(bus.stack_err), 32'h0);
    call(32'h80);
    chk("ovf_sp", 32'(bus.sp), 32'h8);
    chk("ovf_err", 32'(bus.stack_err), 32'h1);
    chk("ovf_pc", bus.pc, TrapEn ? 32'h4 : 32'h80);
    for (int k = 7; k >= 0; k--) begin
      ret();
      chk($sformatf("pop%0d_pc", k), bus.pc, ret_exp[k]);
      chk($sformatf("pop%0d_sp", k), 32'(bus.sp), 32'(k));
    end
    chk("drain_empty", 32'(bus.stack_empty), 32'h1);
    chk("sticky_err", 32'(bus.stack_err), 32'h1);

    do_reset();
    jmp(32'h20);
    commit(2'b10, 0, 0, 0, 1, 0, 1, 32'h999, 16'hFFFC);
    chk("brfl_nt_pc", bus.pc, 32'h21);
    commit(2'b10, 0, 0, 0, 1, 1, 1, 32'h999, 16'hFFFC);
    chk("brfl_t_pc", bus.pc, 32'h1E);
    commit(2'b10, 0, 0, 0, 0, 0, 1, 32'h999, 16'h0005);
    chk("jpc_pc", bus.pc, 32'h24);
    commit(2'b11, 1, 0, 0, 0, 0, 0, 32'h999, 16'h0);
    chk("rsvd_pc", bus.pc, 32'h25);
    chk("rsvd_sp", 32'(bus.sp), 32'h0);
    commit(2'b01, 1, 1, 0, 0, 0, 0, 32'h999, 16'h0);
    chk("pushpop_pc", bus.pc, 32'h26);
    chk("pushpop_sp", 32'(bus.sp), 32'h0);
    chk("pushpop_err", 32'(bus.stack_err), 32'h0);

    jmp(32'hFFFF_FFFF);
    seq();
    chk("wrap_pc", bus.pc, 32'h0);
    ret();
    chk("udf_err", 32'(bus.stack_err), 32'h1);
    chk("udf_sp", 32'(bus.sp), 32'h0);
    chk("udf_pc", bus.pc, TrapEn ? 32'h4 : 32'h1);

    do_reset();
    jmp(32'h30);
    commit(2'b00, 0, 0, 1, 0, 0, 0, 32'h0, 16'h0);
    chk("halt_flag", 32'(bus.halted), 32'h1);
    chk("halt_pc", bus.pc, 32'h30);
    jmp(32'h99);
    jmp(32'h99);
    chk("halted_pc", bus.pc, 32'h30);
    bus.write_pc = 1'b1; bus.branch = 2'b10; bus.reg_target = 32'h55;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_inputs();
    chk("rst_over_pc", bus.pc, 32'h0);
    chk("rst_over_halted", 32'(bus.halted), 32'h0);
    seq();
    chk("post_rst_pc", bus.pc, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
